// File: rtl/sprite_seq_if.sv
// CPU write bus into the sprite frame sequencer (Avalon-style, write-only).
interface sprite_seq_if;
    logic        chipselect;
    logic        write;
    logic [8:0]  address;
    logic [31:0] writedata;

    modport master (output chipselect, output write, output address, output writedata);
    modport slave  (input  chipselect, input  write, input  address, input  writedata);
endinterface

// File: rtl/sprite_frame_sequencer.sv
// Shadow/live sprite register bank committed once per frame at vblank start.
// Define SPRITE_SEQ_ANIM_EN to compile in the dino run animation sequencer.
module sprite_frame_sequencer #(
    parameter int VACTIVE      = 480,
    parameter int ANIM_DEFAULT = 6
) (
    input  logic        clk,
    input  logic        reset,
    sprite_seq_if.slave bus,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [7:0]  dino_x,
    output logic [7:0]  dino_y,
    output logic [7:0]  jump_x,
    output logic [7:0]  jump_y,
    output logic [7:0]  duck_x,
    output logic [7:0]  duck_y,
    output logic [7:0]  s_cac_x,
    output logic [7:0]  s_cac_y,
    output logic [7:0]  godzilla_x,
    output logic [7:0]  godzilla_y,
    output logic [3:0]  score,
    output logic [7:0]  score_x,
    output logic [7:0]  score_y,
    output logic [1:0]  anim_state,
    output logic        commit,
    output logic        pending
);

    localparam int NF = 13;
    localparam int SCORE_IDX = 10;
    localparam logic [8:0] ADDR_CTRL   = 9'd13;
    localparam logic [8:0] ADDR_PERIOD = 9'd14;
    localparam logic [7:0] RST_VAL [NF] = '{8'd100, 8'd100, 8'd200, 8'd150, 8'd40, 8'd200,
                                           8'd250, 8'd100, 8'd105, 8'd220, 8'd0, 8'd25, 8'd41};

    logic [7:0]    shadow [NF];
    logic [7:0]    live   [NF];
    logic [NF-1:0] dirty;
    logic [NF-1:0] dirty_nxt;
    logic [NF-1:0] wr_hit;
    logic          freeze;
    logic          wr_en;
    logic          commit_pt;
    logic          do_commit;

    // The score field is only 4 bits wide; keep its upper shadow bits at zero.
    function automatic logic [7:0] field_val(input int idx, input logic [31:0] data);
        return (idx == SCORE_IDX) ? {4'b0000, data[3:0]} : data[7:0];
    endfunction

    assign wr_en     = bus.chipselect && bus.write;
    assign commit_pt = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
    assign do_commit = commit_pt && !freeze;

    always_comb begin
        for (int i = 0; i < NF; i++) begin
            wr_hit[i] = wr_en && (bus.address == 9'(i));
        end
        // A write on the commit cycle survives the clear and waits for the next frame.
        dirty_nxt = wr_hit | (dirty & ~{NF{do_commit}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NF; i++) begin
                shadow[i] <= RST_VAL[i];
                live[i]   <= RST_VAL[i];
            end
            dirty   <= '0;
            pending <= 1'b0;
            commit  <= 1'b0;
            freeze  <= 1'b0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (do_commit && dirty[i]) live[i] <= shadow[i];
                if (wr_hit[i]) shadow[i] <= field_val(i, bus.writedata);
            end
            dirty   <= dirty_nxt;
            pending <= |dirty_nxt;
            commit  <= do_commit;
            if (wr_en && bus.address == ADDR_CTRL) freeze <= bus.writedata[0];
        end
    end

`ifdef SPRITE_SEQ_ANIM_EN
    typedef enum logic [1:0] {ANIM_0 = 2'd0, ANIM_1 = 2'd1, ANIM_2 = 2'd2} anim_t;
    anim_t      anim_q;
    logic [7:0] frame_cnt;
    logic [7:0] period;
    logic [7:0] period_m1;

    // A period of 0 behaves as 1: advance on every commit.
    assign period_m1 = (period == 8'd0) ? 8'd0 : period - 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anim_q    <= ANIM_0;
            frame_cnt <= 8'd0;
            period    <= 8'(ANIM_DEFAULT);
        end else begin
            if (do_commit) begin
                if (frame_cnt == period_m1) begin
                    frame_cnt <= 8'd0;
                    case (anim_q)
                        ANIM_0:  anim_q <= ANIM_1;
                        ANIM_1:  anim_q <= ANIM_2;
                        default: anim_q <= ANIM_0;
                    endcase
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
            if (wr_en && bus.address == ADDR_PERIOD) begin
                period    <= bus.writedata[7:0];
                frame_cnt <= 8'd0;
            end
        end
    end

    assign anim_state = anim_q;
`else
    assign anim_state = 2'd0;
`endif

    assign dino_x     = live[0];
    assign dino_y     = live[1];
    assign jump_x     = live[2];
    assign jump_y     = live[3];
    assign duck_x     = live[4];
    assign duck_y     = live[5];
    assign s_cac_x    = live[6];
    assign s_cac_y    = live[7];
    assign godzilla_x = live[8];
    assign godzilla_y = live[9];
    assign score      = live[SCORE_IDX][3:0];
    assign score_x    = live[11];
    assign score_y    = live[12];

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Directed self-checking bench for sprite_frame_sequencer (hand-computed expectations).
module tb_sprite_frame_sequencer;
    logic        clk;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  dino_x, dino_y, jump_x, jump_y, duck_x, duck_y;
    logic [7:0]  s_cac_x, s_cac_y, godzilla_x, godzilla_y, score_x, score_y;
    logic [3:0]  score;
    logic [1:0]  anim_state;
    logic        commit, pending;
    int          vectors;
    int          miscompares;

    sprite_seq_if bus ();

    sprite_frame_sequencer #(.VACTIVE(480), .ANIM_DEFAULT(6)) dut (
        .clk(clk), .reset(reset), .bus(bus), .hcount(hcount), .vcount(vcount),
        .dino_x(dino_x), .dino_y(dino_y), .jump_x(jump_x), .jump_y(jump_y),
        .duck_x(duck_x), .duck_y(duck_y), .s_cac_x(s_cac_x), .s_cac_y(s_cac_y),
        .godzilla_x(godzilla_x), .godzilla_y(godzilla_y), .score(score),
        .score_x(score_x), .score_y(score_y), .anim_state(anim_state),
        .commit(commit), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given bus/timing inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic cs, input logic [8:0] a, input logic [31:0] d,
                       input logic [10:0] h, input logic [9:0] v);
        @(negedge clk);
        bus.chipselect = cs;
        bus.write      = cs;
        bus.address    = a;
        bus.writedata  = d;
        hcount         = h;
        vcount         = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [10:0] h, input logic [9:0] v);
        cyc(1'b0, 9'd0, 32'd0, h, v);
    endtask

    task automatic commit_cycle();
        idle(11'd0, 10'd480);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_dino_x"}, dino_x, 100);
        chk({pfx, "_dino_y"}, dino_y, 100);
        chk({pfx, "_jump_x"}, jump_x, 200);
        chk({pfx, "_jump_y"}, jump_y, 150);
        chk({pfx, "_duck_x"}, duck_x, 40);
        chk({pfx, "_duck_y"}, duck_y, 200);
        chk({pfx, "_s_cac_x"}, s_cac_x, 250);
        chk({pfx, "_s_cac_y"}, s_cac_y, 100);
        chk({pfx, "_godzilla_x"}, godzilla_x, 105);
        chk({pfx, "_godzilla_y"}, godzilla_y, 220);
        chk({pfx, "_score"}, score, 0);
        chk({pfx, "_score_x"}, score_x, 25);
        chk({pfx, "_score_y"}, score_y, 41);
        chk({pfx, "_anim"}, anim_state, 0);
        chk({pfx, "_commit"}, commit, 0);
        chk({pfx, "_pending"}, pending, 0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.chipselect = 1'b0;
        bus.write = 1'b0;
        bus.address = 9'd0;
        bus.writedata = 32'd0;
        hcount = 11'd5;
        vcount = 10'd10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(11'd5, 10'd10);
        check_reset_vals("rst");

        // Write dino_x mid-frame; live value waits for the commit point.
        cyc(1'b1, 9'd0, 32'd55, 11'd5, 10'd100);
        chk("dx_pending_rise", pending, 1);
        chk("dx_still_old", dino_x, 100);
        idle(11'd700, 10'd479);
        chk("dx_before_commit", dino_x, 100);
        chk("dx_no_early_commit", commit, 0);
        commit_cycle();
        chk("dx_live", dino_x, 55);
        chk("dx_commit_pulse", commit, 1);
        chk("dx_pending_clear", pending, 0);
        idle(11'd1, 10'd480);
        chk("dx_commit_one_cycle", commit, 0);

        // Unused address and a non-selected write must not mark anything dirty.
        cyc(1'b1, 9'd20, 32'd9, 11'd5, 10'd100);
        chk("bad_addr_pending", pending, 0);

        // Write score on the commit cycle: this commit must not take it.
        cyc(1'b1, 9'd10, 32'd7, 11'd0, 10'd480);
        chk("sc_commit_pulse", commit, 1);
        chk("sc_unchanged", score, 0);
        chk("sc_pending_kept", pending, 1);
        idle(11'd1, 10'd480);
        chk("sc_pending_hold", pending, 1);
        commit_cycle();
        chk("sc_live_next_frame", score, 7);
        chk("sc_pending_clear", pending, 0);

        // Freeze holds live values, commit pulses and the animation.
        cyc(1'b1, 9'd13, 32'd1, 11'd5, 10'd100);
        cyc(1'b1, 9'd3, 32'd30, 11'd6, 10'd100);
        for (int f = 0; f < 3; f++) begin
            commit_cycle();
            chk("frz_jump_y", jump_y, 150);
            chk("frz_no_commit", commit, 0);
            chk("frz_pending", pending, 1);
            chk("frz_anim", anim_state, 0);
            idle(11'd1, 10'd480);
        end
        cyc(1'b1, 9'd13, 32'd0, 11'd5, 10'd100);
        commit_cycle();
        chk("unfrz_jump_y", jump_y, 30);
        chk("unfrz_commit", commit, 1);
        chk("unfrz_pending", pending, 0);

`ifdef SPRITE_SEQ_ANIM_EN
        begin
            logic [1:0] exp_p2 [6];
            logic [1:0] exp_p0 [3];
            exp_p2 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
            exp_p0 = '{2'd1, 2'd2, 2'd0};
            cyc(1'b1, 9'd14, 32'd2, 11'd5, 10'd100);
            chk("p2_start", anim_state, 0);
            chk("p2_not_dirty", pending, 0);
            for (int k = 0; k < 6; k++) begin
                commit_cycle();
                chk("anim_period2", anim_state, exp_p2[k]);
                idle(11'd1, 10'd480);
            end
            cyc(1'b1, 9'd14, 32'd0, 11'd5, 10'd100);
            for (int k = 0; k < 3; k++) begin
                commit_cycle();
                chk("anim_period0", anim_state, exp_p0[k]);
                idle(11'd1, 10'd480);
            end
        end
`else
        cyc(1'b1, 9'd14, 32'd2, 11'd5, 10'd100);
        chk("p_write_ignored", pending, 0);
        for (int k = 0; k < 4; k++) begin
            commit_cycle();
            chk("anim_tied_zero", anim_state, 0);
            idle(11'd1, 10'd480);
        end
`endif

        // Mid-frame asynchronous reset after several pending writes and a freeze.
        cyc(1'b1, 9'd1, 32'd77, 11'd5, 10'd200);
        cyc(1'b1, 9'd11, 32'd99, 11'd6, 10'd200);
        cyc(1'b1, 9'd13, 32'd1, 11'd7, 10'd200);
        chk("pre_rst_pending", pending, 1);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_rst_dino_x", dino_x, 100);
        chk("async_rst_jump_y", jump_y, 150);
        chk("async_rst_score", score, 0);
        chk("async_rst_pending", pending, 0);
        chk("async_rst_anim", anim_state, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(11'd5, 10'd300);
        check_reset_vals("post_rst");
        commit_cycle();
        chk("post_rst_commit", commit, 1);
        chk("post_rst_dino_y", dino_y, 100);
        chk("post_rst_score_x", score_x, 25);
        chk("post_rst_anim", anim_state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
